// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding and ALU control codes for the HI/LO multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

    localparam logic [3:0] ALUCTL_MULT = 4'b1000;
    localparam logic [3:0] ALUCTL_DIV  = 4'b1001;
    localparam logic [3:0] ALUCTL_MFHI = 4'b1010;
    localparam logic [3:0] ALUCTL_MFLO = 4'b1011;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (mode=0) or restoring-divide (mode=1) iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + ({1'b0, opnd} & {(WIDTH+1){acc_lo[0]}});
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        hi_n    = acc_hi;
        lo_n    = acc_lo;
        if (!mode) begin
            // product {acc_hi, acc_lo} shifts right; multiplier bits drain out of acc_lo
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_n = diff[WIDTH-1:0];
            lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = shifted[WIDTH-1:0];
            lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - iterative signed MULT/DIV sequencer owning HI/LO, with pipeline stall
module hilo_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, is_div, div0;
    logic             accept_mul, accept_div;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign accept_mul = start & ~flush & (op == ALUCTL_MULT);
    assign accept_div = start & ~flush & (op == ALUCTL_DIV);

    assign busy  = (state_q != IDLE);
    assign stall = busy & (rd_hilo | start);
    assign done  = (state_q == FIX) & ~flush;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode   (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .hi_n   (step_hi),
        .lo_n   (step_lo)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_mul)      state_d = MUL;
                    else if (accept_div) state_d = DIV;
                end
                MUL:     if (count == '0) state_d = FIX;
                DIV:     if (count == '0) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Divide by zero keeps the all-ones quotient unsigned; re-signing the
    // remainder with the dividend sign restores the raw dividend into HI.
    always_comb begin
        prod_fix = sign_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_hi = sign_r ? -acc_hi : acc_hi;
            fix_lo = (sign_q & ~div0) ? -acc_lo : acc_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept_mul || accept_div) begin
                        acc_hi <= '0;
                        acc_lo <= accept_div ? abs_val(srca) : abs_val(srcb);
                        opnd   <= accept_div ? abs_val(srcb) : abs_val(srca);
                        count  <= CW'(WIDTH - 1);
                        sign_q <= srca[WIDTH-1] ^ srcb[WIDTH-1];
                        sign_r <= srca[WIDTH-1];
                        is_div <= accept_div;
                        div0   <= (srcb == '0);
                    end
                end
                MUL, DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 1'b1;
                end
                FIX: begin
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - directed table-driven bench for hilo_muldiv_seq
module tb_hilo_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] srca, srcb;
    logic        rd_hilo;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .rd_hilo (rd_hilo),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one op and waits for completion; returns busy-cycle and done-pulse counts.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int dones);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        dones  = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (done) dones++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, dn, stalls;
        reset = 1'b0; start = 1'b0; op = 4'b0000; srca = '0; srcb = '0;
        rd_hilo = 1'b0; flush = 1'b0;

        vecs[0]  = '{4'b1000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{4'b1000, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[2]  = '{4'b1000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{4'b1000, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{4'b1000, 32'h7FFF_FFFF,  32'd2,         32'h0000_0000, 32'hFFFF_FFFE};
        vecs[5]  = '{4'b1001, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{4'b1001, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[7]  = '{4'b1001, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{4'b1001, 32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[9]  = '{4'b1001, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[10] = '{4'b1001, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[11] = '{4'b1001, 32'd3,          32'd10,        32'h0000_0003, 32'h0000_0000};

        repeat (2) @(negedge clk);
        chk("reset_busy",  64'(busy),  64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_done",  64'(done),  64'd0);
        chk("reset_hi",    64'(hi),    64'd0);
        chk("reset_lo",    64'(lo),    64'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dn);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'd33);
            chk($sformatf("vec%0d_done_pulses", i), 64'(dn),  64'd1);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end

        // MFHI arriving mid-MULT is stalled through FIX, then sees the new HI
        @(negedge clk);
        start = 1'b1; op = 4'b1000; srca = 32'd7; srcb = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rd_hilo = 1'b1;
        stalls = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            #1;
            if (stall) stalls++;
            cyc++;
            @(negedge clk);
        end
        #1;
        chk("mfhi_stall_cycles", 64'(stalls), 64'd29);
        chk("mfhi_stall_released", 64'(stall), 64'd0);
        chk("mfhi_hi", 64'(hi), 64'hFFFF_FFFF);
        rd_hilo = 1'b0;

        // back-to-back MULT: second held by stall until first IDLE cycle
        @(negedge clk);
        start = 1'b1; op = 4'b1000; srca = 32'd2; srcb = 32'd3;
        @(negedge clk);
        srca = 32'd4; srcb = 32'd5;
        stalls = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            #1;
            if (stall) stalls++;
            cyc++;
            @(negedge clk);
        end
        #1;
        chk("b2b_stall_cycles", 64'(stalls), 64'd33);
        chk("b2b_idle_stall", 64'(stall), 64'd0);
        chk("b2b_first_lo", 64'(lo), 64'd6);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accepted", 64'(busy), 64'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("b2b_second_hi", 64'(hi), 64'd0);
        chk("b2b_second_lo", 64'(lo), 64'd20);

        // flush on cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; op = 4'b1001; srca = 32'd100; srcb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (9) begin
            if (done) dn++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 64'(busy), 64'd0);
        repeat (40) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_hi_kept", 64'(hi), 64'd0);
        chk("flush_lo_kept", 64'(lo), 64'd20);

        start = 1'b1; op = 4'b1001; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ignored", 64'(busy), 64'd0);

        // asynchronous reset between edges mid-MULT
        @(negedge clk);
        start = 1'b1; op = 4'b1000; srca = 32'd9; srcb = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_lo", 64'(lo), 64'd0);
        chk("async_reset_hi", 64'(hi), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1; op = 4'b0010; srca = 32'd5; srcb = 32'd6;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("bad_op_ignored", 64'(busy), 64'd0);
        chk("bad_op_stall", 64'(stall), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
